// File: rtl/fb_draw_arbiter.sv
// Round-robin arbiter sharing one framebuffer blitter among NUM_REQ draw sources.
// Latches the winner's coordinates at grant and recovers the bus on a stalled blitter.
module fb_draw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic                 Clk,
    input  logic                 RESET,
    input  logic                 Hold,
    input  logic [NUM_REQ-1:0]   Req,
    input  logic [NUM_REQ*8-1:0] Req_DrawX,
    input  logic [NUM_REQ*8-1:0] Req_DrawY,
    input  logic [NUM_REQ*7-1:0] Req_SpriteX,
    input  logic [NUM_REQ*7-1:0] Req_SpriteY,
    input  logic [NUM_REQ-1:0]   Req_is_8,
    input  logic                 Done_Draw_FB,
    output logic [7:0]           NewDrawX,
    output logic [7:0]           NewDrawY,
    output logic [6:0]           NewSpriteX,
    output logic [6:0]           NewSpriteY,
    output logic                 is_8,
    output logic                 Draw_FB_EN,
    output logic [NUM_REQ-1:0]   Grant,
    output logic [NUM_REQ-1:0]   Ack,
    output logic                 Busy,
    output logic                 Timeout_Err,
    output logic                 Err_Sticky
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t             state;
    logic [PW-1:0]      rr_ptr;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [PW-1:0]      win;
    logic [NUM_REQ-1:0] win_oh;
    logic [7:0]         sel_dx;
    logic [7:0]         sel_dy;
    logic [6:0]         sel_sx;
    logic [6:0]         sel_sy;
    logic               sel_8;

    // Prefer the lowest request above rr_ptr; otherwise wrap to the lowest overall.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            hi_mask[i] = (i > int'(rr_ptr));
        hi_req = Req & hi_mask;
        win = '0;
        if (hi_req != '0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (hi_req[i]) win = PW'(i);
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--)
                if (Req[i]) win = PW'(i);
        end
    end

    always_comb begin
        win_oh = '0;
        sel_dx = '0;
        sel_dy = '0;
        sel_sx = '0;
        sel_sy = '0;
        sel_8  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PW'(i)) begin
                win_oh[i] = 1'b1;
                sel_dx    = Req_DrawX[8*i +: 8];
                sel_dy    = Req_DrawY[8*i +: 8];
                sel_sx    = Req_SpriteX[7*i +: 7];
                sel_sy    = Req_SpriteY[7*i +: 7];
                sel_8     = Req_is_8[i];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            state       <= IDLE;
            rr_ptr      <= PTR_RST;
            cnt         <= '0;
            NewDrawX    <= '0;
            NewDrawY    <= '0;
            NewSpriteX  <= '0;
            NewSpriteY  <= '0;
            is_8        <= 1'b0;
            Draw_FB_EN  <= 1'b0;
            Grant       <= '0;
            Ack         <= '0;
            Busy        <= 1'b0;
            Timeout_Err <= 1'b0;
            Err_Sticky  <= 1'b0;
        end else begin
            Ack         <= '0;
            Timeout_Err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!Hold && Req != '0) begin
                        NewDrawX   <= sel_dx;
                        NewDrawY   <= sel_dy;
                        NewSpriteX <= sel_sx;
                        NewSpriteY <= sel_sy;
                        is_8       <= sel_8;
                        Grant      <= win_oh;
                        rr_ptr     <= win;
                        cnt        <= '0;
                        Draw_FB_EN <= 1'b1;
                        Busy       <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (Done_Draw_FB) begin
                        Draw_FB_EN <= 1'b0;
                        Ack        <= Grant;
                        state      <= ACK;
                    end else if (cnt == CNT_LAST) begin
                        Draw_FB_EN  <= 1'b0;
                        Ack         <= Grant;
                        Timeout_Err <= 1'b1;
                        Err_Sticky  <= 1'b1;
                        state       <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    Grant <= '0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
